// File: rtl/miner_dispatch_if.sv
// Bus bundle for miner_dispatch: Avalon-MM CSR slave signals plus the shared
// header and the per-core start/nonce/done/hash lanes.
interface miner_dispatch_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int HASH_W    = 256,
    parameter int ADDR_W    = 6
) ();
    // CSR access: a read or write happens on any cycle with avs_chipselect and
    // the strobe high; there is no wait-request and avs_readdata lands one cycle later.
    logic [ADDR_W-1:0]           avs_address;
    logic [31:0]                 avs_writedata;
    logic                        avs_write;
    logic                        avs_read;
    logic                        avs_chipselect;
    logic [31:0]                 avs_readdata;
    logic [607:0]                hdr_out;
    logic [NUM_CORES-1:0]        core_start;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES*HASH_W-1:0] core_hash;
    logic                        irq;

    modport slave (
        input  avs_address, avs_writedata, avs_write, avs_read, avs_chipselect,
        input  core_done, core_hash,
        output avs_readdata, hdr_out, core_start, core_nonce, irq
    );

    modport master (
        output avs_address, avs_writedata, avs_write, avs_read, avs_chipselect,
        output core_done, core_hash,
        input  avs_readdata, hdr_out, core_start, core_nonce, irq
    );
endinterface

// File: rtl/miner_dispatch.sv
// Multi-core nonce dispatcher with Avalon-MM CSRs; compares core hashes to TARGET.
// Optional MINER_HASHCOUNT_EN adds a saturating count of accepted results at addr 32.
module miner_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int HASH_W    = 256,
    parameter int ADDR_W    = 6
) (
    input  logic            clk,
    input  logic            rst,
    miner_dispatch_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    logic [31:0]            r_target [8];
    logic [31:0]            r_header [19];
    logic [NONCE_W-1:0]     r_nonce_start;
    logic [NONCE_W-1:0]     r_nonce_end;
    logic [NONCE_W-1:0]     r_found_nonce;
    logic [NONCE_W:0]       r_next_nonce;
    logic [NONCE_W-1:0]     r_core_nonce [NUM_CORES];
    logic [NUM_CORES-1:0]   r_core_busy;
    logic [NUM_CORES-1:0]   r_core_start;
    logic                   r_busy, r_done, r_found, r_exhausted, r_aborted, r_wr_err;
    logic                   r_abort_req;
    logic [31:0]            r_readdata;

    logic [31:0]            w_addr;
    logic                   w_wr, w_rd, w_ctrl_wr, w_start, w_abort, w_clear, w_launch;
    logic [2:0]             w_toff;
    logic [4:0]             w_hoff;
    logic [HASH_W-1:0]      w_target;
    logic [NUM_CORES-1:0]   w_accept;
    logic [NUM_CORES-1:0]   w_hit;
    logic                   w_hit_any;
    logic [NONCE_W-1:0]     w_hit_nonce;
    logic                   w_idle_any;
    logic [IDX_W-1:0]       w_idle_idx;
    logic                   w_range_left;
    logic                   w_any_busy;
    logic [31:0]            w_rdata;
    logic [31:0]            w_hash_count;

    assign w_addr    = 32'(bus.avs_address);
    assign w_wr      = bus.avs_chipselect & bus.avs_write;
    assign w_rd      = bus.avs_chipselect & bus.avs_read;
    assign w_ctrl_wr = w_wr && (w_addr == 32'd0);
    // Abort in the same CTRL write suppresses start.
    assign w_start   = w_ctrl_wr & bus.avs_writedata[0] & ~bus.avs_writedata[1];
    assign w_abort   = w_ctrl_wr & bus.avs_writedata[1];
    assign w_clear   = w_ctrl_wr & bus.avs_writedata[2];
    assign w_launch  = w_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_toff    = 3'(w_addr - 32'd5);
    assign w_hoff    = 5'(w_addr - 32'd13);

    assign w_range_left = (r_next_nonce <= {1'b0, r_nonce_end});
    assign w_any_busy   = |r_core_busy;
    assign w_accept     = bus.core_done & r_core_busy;

    always_comb begin
        w_target = '0;
        for (int i = 0; i < 8; i++) w_target[HASH_W-32*(i+1) +: 32] = r_target[i];
    end

    // Scan from the top so the lowest index wins for both hits and idle cores.
    always_comb begin
        w_hit       = '0;
        w_hit_any   = 1'b0;
        w_hit_nonce = '0;
        w_idle_any  = 1'b0;
        w_idle_idx  = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            w_hit[c] = w_accept[c] && (bus.core_hash[c*HASH_W +: HASH_W] < w_target);
            if (w_hit[c]) begin
                w_hit_any   = 1'b1;
                w_hit_nonce = r_core_nonce[c];
            end
            if (!r_core_busy[c]) begin
                w_idle_any = 1'b1;
                w_idle_idx = IDX_W'(c);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_addr == 32'd1)
            w_rdata = {26'd0, r_wr_err, r_aborted, r_exhausted, r_found, r_done, r_busy};
        else if (w_addr == 32'd2)
            w_rdata = 32'(r_found_nonce);
        else if (w_addr == 32'd3)
            w_rdata = 32'(r_nonce_start);
        else if (w_addr == 32'd4)
            w_rdata = 32'(r_nonce_end);
        else if (w_addr >= 32'd5 && w_addr <= 32'd12)
            w_rdata = r_target[w_toff];
        else if (w_addr >= 32'd13 && w_addr <= 32'd31)
            w_rdata = r_header[w_hoff];
        else if (w_addr == 32'd32)
            w_rdata = w_hash_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_nonce_start <= '0;
            r_nonce_end   <= '0;
            r_found_nonce <= '0;
            r_next_nonce  <= '0;
            r_core_busy   <= '0;
            r_core_start  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_aborted     <= 1'b0;
            r_wr_err      <= 1'b0;
            r_abort_req   <= 1'b0;
            r_readdata    <= '0;
            for (int i = 0; i < 8; i++) r_target[i] <= '0;
            for (int i = 0; i < 19; i++) r_header[i] <= '0;
            for (int c = 0; c < NUM_CORES; c++) r_core_nonce[c] <= '0;
        end else begin
            r_core_start <= '0;
            r_core_busy  <= r_core_busy & ~w_accept;

            if (w_rd) r_readdata <= w_rdata;

            if (w_wr && w_addr >= 32'd3 && w_addr <= 32'd31) begin
                if (r_busy)                 r_wr_err <= 1'b1;
                else if (w_addr == 32'd3)   r_nonce_start <= NONCE_W'(bus.avs_writedata);
                else if (w_addr == 32'd4)   r_nonce_end <= NONCE_W'(bus.avs_writedata);
                else if (w_addr <= 32'd12)  r_target[w_toff] <= bus.avs_writedata;
                else                        r_header[w_hoff] <= bus.avs_writedata;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state       <= S_RUN;
                        r_busy        <= 1'b1;
                        r_next_nonce  <= {1'b0, r_nonce_start};
                        r_done        <= 1'b0;
                        r_found       <= 1'b0;
                        r_exhausted   <= 1'b0;
                        r_aborted     <= 1'b0;
                        r_found_nonce <= '0;
                        r_abort_req   <= 1'b0;
                    end else if (w_clear) begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b0;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_aborted   <= 1'b0;
                        r_wr_err    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state     <= S_DRAIN;
                        r_abort_req <= 1'b1;
                    end else if (w_hit_any) begin
                        r_found_nonce <= w_hit_nonce;
                        r_found       <= 1'b1;
                        r_state       <= S_DRAIN;
                    end else if (w_range_left) begin
                        if (w_idle_any) begin
                            r_core_start[w_idle_idx] <= 1'b1;
                            r_core_busy[w_idle_idx]  <= 1'b1;
                            r_core_nonce[w_idle_idx] <= r_next_nonce[NONCE_W-1:0];
                            r_next_nonce             <= r_next_nonce + 1'b1;
                        end
                    end else if (!w_any_busy) begin
                        // Busy bits are registered, so the final result was already compared.
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_exhausted <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!w_any_busy) begin
                        r_busy <= 1'b0;
                        if (r_abort_req) begin
                            r_state   <= S_IDLE;
                            r_aborted <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MINER_HASHCOUNT_EN
    logic [31:0] r_hash_count;
    logic [32:0] w_count_sum;

    assign w_count_sum = {1'b0, r_hash_count} + 33'($countones(w_accept));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_hash_count <= '0;
        else if (w_launch)        r_hash_count <= '0;
        else if (w_count_sum[32]) r_hash_count <= '1;
        else                      r_hash_count <= w_count_sum[31:0];
    end

    assign w_hash_count = r_hash_count;
`else
    assign w_hash_count = '0;
`endif

    for (genvar g = 0; g < 19; g++) begin : g_hdr
        assign bus.hdr_out[608-32*(g+1) +: 32] = r_header[g];
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce
        assign bus.core_nonce[g*NONCE_W +: NONCE_W] = r_core_nonce[g];
    end

    assign bus.core_start   = r_core_start;
    assign bus.avs_readdata = r_readdata;
    assign bus.irq          = r_done;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_miner_dispatch.sv
// Bench for miner_dispatch: two modelled SHA cores with table-driven hashes and a
// range-scan reference model of the expected winner, status and dispatch order.
module tb_miner_dispatch;
    localparam int NC = 2;
    localparam int NW = 32;
    localparam int HW = 256;
    localparam int AW = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    miner_dispatch_if #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW), .ADDR_W(AW)) bus ();

    miner_dispatch #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] disp_q[$];
    logic [31:0] hit_q[$];
    logic [31:0] hdr_exp[19];
    int          lat[NC];
    int          cd[NC];
    logic [31:0] nn[NC];
    int          multi_disp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] n);
        foreach (hit_q[i]) if (hit_q[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // Target is 0x00000001_00..00: hits get a zero top word, misses a top word
    // of at least 1 (sometimes exactly equal to the target, which is not a hit).
    function automatic logic [255:0] make_hash(input logic [31:0] n);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
        if (is_hit(n)) h[255:224] = 32'd0;
        else if ($urandom_range(0, 3) == 0) begin
            h[255:224] = 32'd1;
            h[223:0]   = '0;
        end else h[255:224] = $urandom | 32'd1;
        return h;
    endfunction

    // Core models: result pulse lat[c] cycles after start is seen; recorder of dispatches.
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            bus.core_done[c] = 1'b0;
            if (cd[c] > 0) begin
                cd[c]--;
                if (cd[c] == 0) begin
                    bus.core_done[c] = 1'b1;
                    bus.core_hash[c*HW +: HW] = make_hash(nn[c]);
                end
            end
            if (bus.core_start[c] === 1'b1) begin
                nn[c] = bus.core_nonce[c*NW +: NW];
                cd[c] = lat[c];
                disp_q.push_back(nn[c]);
            end
        end
        if ($countones(bus.core_start) > 1) multi_disp++;
    end

    task automatic csr_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = AW'(addr);
        bus.avs_writedata  = data;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
    endtask

    task automatic csr_read(input int addr, output logic [31:0] data);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = AW'(addr);
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        data = bus.avs_readdata;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        s = 32'd1;
        n = 0;
        while (s[0] && n < 1500) begin
            csr_read(1, s);
            n++;
        end
        check_eq("run_timeout", 32'(s[0]), 32'd0);
        if (s[0]) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic do_run(input logic [31:0] s, input logic [31:0] e);
        csr_write(3, s);
        csr_write(4, e);
        disp_q.delete();
        multi_disp = 0;
        csr_write(0, 32'h1);
        wait_idle();
    endtask

    // Reference: scan the range in nonce order; the first hitting nonce wins.
    task automatic model_check(input string tag, input logic [31:0] s, input logic [31:0] e);
        longint first = -1;
        longint len;
        logic [31:0] rd;
        len = (e >= s) ? longint'(e) - longint'(s) + 1 : 0;
        exp_q.delete();
        for (longint n = s; n <= longint'(e); n++) begin
            exp_q.push_back(32'(n));
            if (first < 0 && is_hit(32'(n))) first = n;
        end
        csr_read(1, rd);
        if (first >= 0) begin
            check_eq({tag, "_status"}, rd, 32'h06);
            csr_read(2, rd);
            check_eq({tag, "_found"}, rd, 32'(first));
            check_eq({tag, "_disp_le"}, 32'(disp_q.size() <= len), 32'd1);
            check_eq({tag, "_disp_ge"}, 32'(disp_q.size() >= first - longint'(s) + 1), 32'd1);
        end else begin
            check_eq({tag, "_status"}, rd, 32'h0A);
            csr_read(2, rd);
            check_eq({tag, "_found"}, rd, 32'd0);
            check_eq({tag, "_disp_n"}, 32'(disp_q.size()), 32'(len));
            csr_read(32, rd);
`ifdef MINER_HASHCOUNT_EN
            check_eq({tag, "_hcount"}, rd, 32'(len));
`else
            check_eq({tag, "_hcount"}, rd, 32'd0);
`endif
        end
        for (int i = 0; i < disp_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_disp_seq"}, disp_q[i], exp_q[i]);
        check_eq({tag, "_irq"}, 32'(bus.irq), 32'd1);
        check_eq({tag, "_one_disp"}, 32'(multi_disp), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] s;
        logic [31:0] e;
        logic [607:0] hv;
        int len;

        rst = 1'b1;
        bus.avs_address    = '0;
        bus.avs_writedata  = '0;
        bus.avs_write      = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_chipselect = 1'b0;
        lat[0] = 5;
        lat[1] = 5;
        repeat (3) @(negedge clk);
        check_eq("rst_readdata", bus.avs_readdata, 32'd0);
        check_eq("rst_start", 32'(bus.core_start), 32'd0);
        check_eq("rst_irq", 32'(bus.irq), 32'd0);
        check_eq("rst_hdr", 32'(bus.hdr_out != '0), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        csr_read(1, rd);
        check_eq("rst_status", rd, 32'd0);

        csr_write(5, 32'd1);
        for (int i = 6; i <= 12; i++) csr_write(i, 32'd0);
        for (int i = 0; i < 19; i++) begin
            hdr_exp[i] = $urandom;
            csr_write(13 + i, hdr_exp[i]);
        end
        for (int i = 0; i < 19; i++) hv[608-32*(i+1) +: 32] = hdr_exp[i];
        check_eq("hdr_out", 32'(bus.hdr_out == hv), 32'd1);
        csr_read(31, rd);
        check_eq("hdr_rd18", rd, hdr_exp[18]);
        csr_read(6, rd);
        check_eq("target_rd", rd, 32'd0);

        hit_q = '{32'h12};
        do_run(32'h10, 32'h13);
        model_check("t1", 32'h10, 32'h13);

        hit_q.delete();
        do_run(32'h0, 32'h7);
        model_check("t2", 32'h0, 32'h7);

        lat[0] = 6;
        hit_q = '{32'h20, 32'h21};
        do_run(32'h20, 32'h21);
        model_check("t3", 32'h20, 32'h21);
        lat[0] = 5;

        hit_q = '{32'h40, 32'h41};
        csr_write(3, 32'h40);
        csr_write(4, 32'h100);
        csr_write(0, 32'h1);
        repeat (2) @(negedge clk);
        csr_write(0, 32'h2);
        wait_idle();
        csr_read(1, rd);
        check_eq("t4_status", rd, 32'h10);
        csr_read(2, rd);
        check_eq("t4_found", rd, 32'd0);
        check_eq("t4_irq", 32'(bus.irq), 32'd0);
        csr_write(0, 32'h4);
        csr_read(1, rd);
        check_eq("t4_clear", rd, 32'd0);
        csr_write(0, 32'h1);
        csr_write(13, ~hdr_exp[0]);
        csr_write(0, 32'h2);
        wait_idle();
        csr_read(1, rd);
        check_eq("t4_wrerr_status", rd, 32'h30);
        csr_read(13, rd);
        check_eq("t4_hdr_kept", rd, hdr_exp[0]);
        csr_write(0, 32'h4);
        csr_read(1, rd);
        check_eq("t4_clear2", rd, 32'd0);

        hit_q.delete();
        do_run(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        model_check("t5", 32'hFFFF_FFFE, 32'hFFFF_FFFF);

        do_run(32'h50, 32'h4F);
        model_check("empty", 32'h50, 32'h4F);

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 12);
            s = $urandom_range(0, 32'hFFFF_0000);
            e = s + 32'(len - 1);
            hit_q.delete();
            for (int k = 0; k < len; k++)
                if ($urandom_range(0, 3) == 0) hit_q.push_back(s + 32'(k));
            if ($urandom_range(0, 1) == 0) csr_write(0, 32'h4);
            do_run(s, e);
            model_check("rand", s, e);
        end

        hit_q.delete();
        csr_write(3, 32'h0);
        csr_write(4, 32'h1000);
        csr_write(0, 32'h1);
        csr_read(1, rd);
        check_eq("t6_busy", rd, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_readdata", bus.avs_readdata, 32'd0);
        check_eq("t6_start", 32'(bus.core_start), 32'd0);
        check_eq("t6_nonce", 32'(bus.core_nonce != '0), 32'd0);
        check_eq("t6_irq", 32'(bus.irq), 32'd0);
        check_eq("t6_hdr", 32'(bus.hdr_out != '0), 32'd0);
        check_eq("t6_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        csr_read(1, rd);
        check_eq("t6_status", rd, 32'd0);
        csr_read(13, rd);
        check_eq("t6_hdr_rd", rd, 32'd0);

        csr_write(3, 32'h0);
        csr_write(4, 32'h3);
        disp_q.delete();
        csr_write(0, 32'h3);
        repeat (10) @(negedge clk);
        check_eq("sa_disp", 32'(disp_q.size()), 32'd0);
        check_eq("sa_state", 32'(dbg_state), 32'd0);
        csr_read(1, rd);
        check_eq("sa_status", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
